// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: producer op classes and the
// default stall windows also used by the control and forwarding units.
package hazard_scoreboard_pkg;

  typedef logic [1:0] op_class_t;

  localparam op_class_t OPC_ALU  = 2'd0;
  localparam op_class_t OPC_LOAD = 2'd1;
  localparam op_class_t OPC_LONG = 2'd2;

  localparam int DEF_REG_AW   = 5;
  localparam int DEF_ALU_LAT  = 0;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_LONG_LAT = 4;
  localparam int DEF_CNT_W    = 3;

  // Stall window for a producer; the reserved class 3 behaves like LONG.
  function automatic int lat_sel(input op_class_t opc, input int alu_lat,
                                 input int load_lat, input int long_lat);
    case (opc)
      OPC_ALU:  return alu_lat;
      OPC_LOAD: return load_lat;
      default:  return long_lat;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage handshake between the pipeline control (master) and the
// hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);
  import hazard_scoreboard_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  op_class_t         id_op_class;
  logic              flush_id;
  logic              pipe_freeze;
  logic              pc_write;
  logic              if_id_write;
  logic              is_hazard;
  logic [31:0]       hazard_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_op_class, flush_id, pipe_freeze,
    input  pc_write, if_id_write, is_hazard, hazard_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_op_class, flush_id, pipe_freeze,
    output pc_write, if_id_write, is_hazard, hazard_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard entry: a countdown of the cycles until its register's
// pending result can be consumed. A new load overrides any count in flight.
module sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on issue, otherwise count down to zero; hold when frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls the ID stage while a source
// operand is still being produced, and counts stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int LONG_LAT = DEF_LONG_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic          clk,
  input logic          reset_n,
  hazard_scoreboard_if.slave sb
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] lat_val;
  logic             hz1;
  logic             hz2;
  logic             stall;
  logic             issue;
  logic             run;
  logic [31:0]      hazard_cycles_q;
  logic [31:0]      hazard_cycles_d;

  // x0 is hard-wired and never has a pending producer.
  assign busy[0] = 1'b0;
  assign run     = ~sb.pipe_freeze;

  // Source-hazard detection, stall and issue qualification.
  always_comb begin
    hz1     = sb.id_use_rs1 && (sb.id_rs1 != '0) && busy[sb.id_rs1];
    hz2     = sb.id_use_rs2 && (sb.id_rs2 != '0) && busy[sb.id_rs2];
    stall   = sb.id_valid && !sb.flush_id && (hz1 || hz2);
    issue   = sb.id_valid && sb.id_reg_write && (sb.id_rd != '0) &&
              !stall && !sb.flush_id && !sb.pipe_freeze;
    lat_val = CNT_W'(lat_sel(sb.id_op_class, ALU_LAT, LOAD_LAT, LONG_LAT));
  end

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cell
      sb_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (run),
        .load     (issue && (sb.id_rd == REG_AW'(gi))),
        .load_val (lat_val),
        .busy     (busy[gi])
      );
    end
  endgenerate

  // Stall-cycle counter: counts unfrozen stall edges and sticks at all-ones.
  always_comb begin
    hazard_cycles_d = hazard_cycles_q;
    if (stall && run && (hazard_cycles_q != 32'hFFFF_FFFF)) begin
      hazard_cycles_d = hazard_cycles_q + 32'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hazard_cycles_q <= '0;
    end else begin
      hazard_cycles_q <= hazard_cycles_d;
    end
  end

  assign sb.is_hazard     = stall;
  assign sb.pc_write      = ~stall;
  assign sb.if_id_write   = ~stall;
  assign sb.hazard_cycles = hazard_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a default (forwarding) instance and a no-forwarding
// instance (ALU_LAT=3) share identical ID-stage stimulus.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, flush_id, pipe_freeze;
  logic [4:0] id_rs1, id_rs2, id_rd;
  op_class_t  id_op_class;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5)) ifa ();
  hazard_scoreboard_if #(.REG_AW(5)) ifb ();

  assign ifa.id_valid = id_valid;         assign ifb.id_valid = id_valid;
  assign ifa.id_rs1 = id_rs1;             assign ifb.id_rs1 = id_rs1;
  assign ifa.id_rs2 = id_rs2;             assign ifb.id_rs2 = id_rs2;
  assign ifa.id_use_rs1 = id_use_rs1;     assign ifb.id_use_rs1 = id_use_rs1;
  assign ifa.id_use_rs2 = id_use_rs2;     assign ifb.id_use_rs2 = id_use_rs2;
  assign ifa.id_rd = id_rd;               assign ifb.id_rd = id_rd;
  assign ifa.id_reg_write = id_reg_write; assign ifb.id_reg_write = id_reg_write;
  assign ifa.id_op_class = id_op_class;   assign ifb.id_op_class = id_op_class;
  assign ifa.flush_id = flush_id;         assign ifb.flush_id = flush_id;
  assign ifa.pipe_freeze = pipe_freeze;   assign ifb.pipe_freeze = pipe_freeze;

  hazard_scoreboard dut_a (.clk(clk), .reset_n(reset_n), .sb(ifa));

  hazard_scoreboard #(.ALU_LAT(3)) dut_b (.clk(clk), .reset_n(reset_n), .sb(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rd, input logic wr, input op_class_t opc,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    id_valid = v; id_rd = rd; id_reg_write = wr; id_op_class = opc;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, OPC_ALU, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    flush_id = 1'b0;
    pipe_freeze = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Holds the current ID instruction until neither instance stalls (bounded),
  // returning per-instance stall-cycle counts.
  task automatic measure(output int sa, output int sbn, output int pca, output int ifd);
    logic ha, hb;
    sa = 0; sbn = 0; pca = 0; ifd = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ha = ifa.is_hazard;
      hb = ifb.is_hazard;
      if (ha) sa++;
      if (hb) sbn++;
      if (!ifa.pc_write) pca++;
      if (!ifa.if_id_write) ifd++;
      tick();
      if (!ha && !hb) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    n_checks += 5;
    if (ifa.pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write: got %b expected 1", ifa.pc_write); end
    if (ifa.if_id_write !== 1'b1) begin n_fail++; $display("FAIL reset_if_id_write: got %b expected 1", ifa.if_id_write); end
    if (ifa.is_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_is_hazard: got %b expected 0", ifa.is_hazard); end
    if (ifa.hazard_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_hc_a: got %0d expected 0", ifa.hazard_cycles); end
    if (ifb.is_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_is_hazard_b: got %b expected 0", ifb.is_hazard); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    int sa, sbn, pca, ifd;
    do_reset();
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd1, 1'b1);
    measure(sa, sbn, pca, ifd);
    idle();
    @(negedge clk);
    n_checks += 4;
    if (sa !== 1) begin n_fail++; $display("FAIL load_use_stalls: got %0d expected 1", sa); end
    if (pca !== 1) begin n_fail++; $display("FAIL load_use_pc_write_low: got %0d expected 1", pca); end
    if (ifd !== 1) begin n_fail++; $display("FAIL load_use_if_id_low: got %0d expected 1", ifd); end
    if (ifa.hazard_cycles !== 32'd1) begin n_fail++; $display("FAIL load_use_hc: got %0d expected 1", ifa.hazard_cycles); end
    $display("test_load_use stalls=%0d hc=%0d", sa, ifa.hazard_cycles);
  endtask

  task automatic test_alu_chain();
    int sa, sbn, pca, ifd;
    do_reset();
    drv(1'b1, 5'd5, 1'b1, OPC_ALU, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd2, 1'b1);
    measure(sa, sbn, pca, ifd);
    idle();
    @(negedge clk);
    n_checks += 4;
    if (sa !== 0) begin n_fail++; $display("FAIL alu_chain_stalls: got %0d expected 0", sa); end
    if (ifa.hazard_cycles !== 32'd0) begin n_fail++; $display("FAIL alu_chain_hc: got %0d expected 0", ifa.hazard_cycles); end
    if (sbn !== 3) begin n_fail++; $display("FAIL nofwd_alu_stalls: got %0d expected 3", sbn); end
    if (ifb.hazard_cycles !== 32'd3) begin n_fail++; $display("FAIL nofwd_alu_hc: got %0d expected 3", ifb.hazard_cycles); end
    $display("test_alu_chain stalls_a=%0d stalls_b=%0d", sa, sbn);
  endtask

  task automatic test_long();
    int sa, sbn, pca, ifd;
    do_reset();
    drv(1'b1, 5'd7, 1'b1, OPC_LONG, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd8, 1'b1, OPC_ALU, 5'd7, 1'b0, 5'd7, 1'b1);
    measure(sa, sbn, pca, ifd);
    idle();
    @(negedge clk);
    n_checks += 3;
    if (sa !== 4) begin n_fail++; $display("FAIL long_rs2_stalls: got %0d expected 4", sa); end
    if (pca !== 4) begin n_fail++; $display("FAIL long_pc_write_low: got %0d expected 4", pca); end
    if (ifa.hazard_cycles !== 32'd4) begin n_fail++; $display("FAIL long_hc: got %0d expected 4", ifa.hazard_cycles); end
    $display("test_long stalls=%0d hc=%0d", sa, ifa.hazard_cycles);
    // Reserved class 3 behaves as LONG.
    do_reset();
    drv(1'b1, 5'd9, 1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd10, 1'b1, OPC_ALU, 5'd9, 1'b1, 5'd0, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 4) begin n_fail++; $display("FAIL reserved_class_stalls: got %0d expected 4", sa); end
    $display("test_long reserved stalls=%0d", sa);
  endtask

  task automatic test_x0_unused();
    int sa, sbn, pca, ifd;
    do_reset();
    drv(1'b1, 5'd0, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd0, 1'b1, 5'd0, 1'b1);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 0) begin n_fail++; $display("FAIL x0_stalls: got %0d expected 0", sa); end
    drv(1'b1, 5'd9, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd9, 1'b0, 5'd9, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 0) begin n_fail++; $display("FAIL unused_src_stalls: got %0d expected 0", sa); end
    drv(1'b1, 5'd9, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 5'd6, 1'b1, OPC_ALU, 5'd9, 1'b1, 5'd9, 1'b1);
    @(negedge clk);
    n_checks++;
    if (ifa.is_hazard !== 1'b0) begin n_fail++; $display("FAIL invalid_id_hazard: got %b expected 0", ifa.is_hazard); end
    $display("test_x0_unused done");
  endtask

  task automatic test_freeze_flush();
    int sa, sbn, pca, ifd;
    do_reset();
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    pipe_freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks += 2;
      if (ifa.is_hazard !== 1'b1) begin n_fail++; $display("FAIL freeze_hazard_%0d: got %b expected 1", k, ifa.is_hazard); end
      if (ifa.hazard_cycles !== 32'd0) begin n_fail++; $display("FAIL freeze_hc_%0d: got %0d expected 0", k, ifa.hazard_cycles); end
      tick();
    end
    pipe_freeze = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.is_hazard !== 1'b1) begin n_fail++; $display("FAIL unfreeze_hazard: got %b expected 1", ifa.is_hazard); end
    tick();
    @(negedge clk);
    n_checks += 2;
    if (ifa.is_hazard !== 1'b0) begin n_fail++; $display("FAIL post_freeze_hazard: got %b expected 0", ifa.is_hazard); end
    if (ifa.hazard_cycles !== 32'd1) begin n_fail++; $display("FAIL post_freeze_hc: got %0d expected 1", ifa.hazard_cycles); end
    // A frozen producer must not issue.
    do_reset();
    pipe_freeze = 1'b1;
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    pipe_freeze = 1'b0;
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 0) begin n_fail++; $display("FAIL frozen_issue_stalls: got %0d expected 0", sa); end
    // A flushed producer is not recorded.
    do_reset();
    flush_id = 1'b1;
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    flush_id = 1'b0;
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 0) begin n_fail++; $display("FAIL flush_producer_stalls: got %0d expected 0", sa); end
    // A flushed consumer does not stall.
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    flush_id = 1'b1;
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    n_checks += 2;
    if (ifa.is_hazard !== 1'b0) begin n_fail++; $display("FAIL flush_consumer_hazard: got %b expected 0", ifa.is_hazard); end
    if (ifa.pc_write !== 1'b1) begin n_fail++; $display("FAIL flush_consumer_pc_write: got %b expected 1", ifa.pc_write); end
    tick();
    flush_id = 1'b0;
    $display("test_freeze_flush done");
  endtask

  task automatic test_overwrite_reset();
    int sa, sbn, pca, ifd;
    // LONG x5, one idle cycle, then ALU x5: younger producer reloads the entry.
    do_reset();
    drv(1'b1, 5'd5, 1'b1, OPC_LONG, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    tick();
    drv(1'b1, 5'd5, 1'b1, OPC_ALU, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks += 2;
    if (sbn !== 3) begin n_fail++; $display("FAIL overwrite_nofwd_stalls: got %0d expected 3", sbn); end
    if (sa !== 0) begin n_fail++; $display("FAIL overwrite_lat0_stalls: got %0d expected 0", sa); end
    // LONG x5 immediately followed by LOAD x5: shorter window wins.
    do_reset();
    drv(1'b1, 5'd5, 1'b1, OPC_LONG, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd5, 1'b1, OPC_LOAD, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd6, 1'b1, OPC_ALU, 5'd5, 1'b1, 5'd0, 1'b0);
    measure(sa, sbn, pca, ifd);
    n_checks++;
    if (sa !== 1) begin n_fail++; $display("FAIL overwrite_shorter_stalls: got %0d expected 1", sa); end
    // Reset in the middle of a LONG stall releases it.
    do_reset();
    drv(1'b1, 5'd7, 1'b1, OPC_LONG, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd8, 1'b1, OPC_ALU, 5'd7, 1'b1, 5'd0, 1'b0);
    tick();
    @(negedge clk);
    n_checks += 2;
    if (ifb.is_hazard !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hazard: got %b expected 1", ifb.is_hazard); end
    if (ifb.hazard_cycles !== 32'd1) begin n_fail++; $display("FAIL pre_reset_hc: got %0d expected 1", ifb.hazard_cycles); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (ifb.is_hazard !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hazard: got %b expected 0", ifb.is_hazard); end
    if (ifb.pc_write !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pc_write: got %b expected 1", ifb.pc_write); end
    if (ifb.hazard_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_hc_b: got %0d expected 0", ifb.hazard_cycles); end
    if (ifa.hazard_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_hc_a: got %0d expected 0", ifa.hazard_cycles); end
    $display("test_overwrite_reset done");
  endtask

  initial begin
    idle();
    flush_id = 1'b0;
    pipe_freeze = 1'b0;
    test_reset();
    test_load_use();
    test_alu_chain();
    test_long();
    test_x0_unused();
    test_freeze_flush();
    test_overwrite_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
